// File: rtl/priority_encoder_8_3.sv
// Sequential 8-to-3 priority encoder: sticky pending events are emitted one at a
// time as 3-bit codes over a valid/ready handshake, lowest index first.
module priority_encoder_8_3 #(
    parameter int N = 8,
    parameter int W = 3
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic [N-1:0] req,
    input  logic         out_ready,
    output logic         out_valid,
    output logic [W-1:0] out_code,
    output logic [N-1:0] pending,
    output logic [W:0]   pend_cnt,
    output logic         ovf
);

    // Isolates the lowest set bit of a vector (two's-complement trick).
    function automatic logic [N-1:0] lowest_one(input logic [N-1:0] v);
        return v & (~v + {{(N-1){1'b0}}, 1'b1});
    endfunction

    // Converts a one-hot (or zero) vector into its bit index.
    function automatic logic [W-1:0] onehot_to_index(input logic [N-1:0] oh);
        logic [W-1:0] idx;
        idx = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            if (oh[i]) begin
                idx = idx | i[W-1:0];
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Counts the set bits of a vector.
    function automatic logic [W:0] popcount(input logic [N-1:0] v);
        logic [W:0] cnt;
        cnt = {(W+1){1'b0}};
        for (int i = 0; i < N; i++) begin
            cnt = cnt + {{W{1'b0}}, v[i]};
        end
        return cnt;
    endfunction

    logic [N-1:0] pend_q;
    logic [N-1:0] pend_d;
    logic         valid_q;
    logic         valid_d;
    logic [W-1:0] code_q;
    logic [W-1:0] code_d;
    logic         ovf_q;
    logic         ovf_d;

    logic         load_s;
    logic         any_pend_s;
    logic [N-1:0] grant_s;

    // Grant selection and next-state computation for pending, output and ovf.
    always_comb begin
        load_s     = !valid_q || out_ready;
        any_pend_s = |pend_q;
        grant_s    = {N{1'b0}};
        valid_d    = valid_q;
        code_d     = code_q;

        if (load_s && any_pend_s) begin
            grant_s = lowest_one(pend_q);
            valid_d = 1'b1;
            code_d  = onehot_to_index(grant_s);
        end else if (load_s) begin
            valid_d = 1'b0;
        end else begin
            valid_d = valid_q;
        end

        // A request landing on the bit being granted re-arms it rather than counting as overflow.
        pend_d = (pend_q & ~grant_s) | req;
        ovf_d  = |(req & pend_q & ~grant_s);
    end

    // State registers with synchronous active-low reset and synchronous clear.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pend_q  <= {N{1'b0}};
            valid_q <= 1'b0;
            code_q  <= {W{1'b0}};
            ovf_q   <= 1'b0;
        end else if (clr) begin
            pend_q  <= {N{1'b0}};
            valid_q <= 1'b0;
            code_q  <= {W{1'b0}};
            ovf_q   <= 1'b0;
        end else begin
            pend_q  <= pend_d;
            valid_q <= valid_d;
            code_q  <= code_d;
            ovf_q   <= ovf_d;
        end
    end

    assign out_valid = valid_q;
    assign out_code  = code_q;
    assign pending   = pend_q;
    assign ovf       = ovf_q;
    assign pend_cnt  = popcount(pend_q);

endmodule

// File: tb/tb_priority_encoder_8_3.sv
// Directed bench for priority_encoder_8_3: an event-set model checked every cycle,
// plus literal expectations for each scenario.
module tb_priority_encoder_8_3;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] req = 8'h00;
    logic       out_ready = 1'b0;
    logic       out_valid;
    logic [2:0] out_code;
    logic [7:0] pending;
    logic [3:0] pend_cnt;
    logic       ovf;

    int pass_cnt = 0;
    int total_cnt = 0;
    bit cmp_en = 1'b0;

    priority_encoder_8_3 dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .clr       (clr),
        .req       (req),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_code  (out_code),
        .pending   (pending),
        .pend_cnt  (pend_cnt),
        .ovf       (ovf)
    );

    always #5 clk = ~clk;

    // Model: set of pending event indices plus the output slot.
    bit m_pend [8];
    bit m_v;
    int m_c;
    bit m_ovf;

    function automatic int model_cnt();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m_pend[i];
        return n;
    endfunction

    function automatic logic [7:0] model_vec();
        logic [7:0] v = 8'h00;
        for (int i = 0; i < 8; i++) v[i] = m_pend[i];
        return v;
    endfunction

    always @(posedge clk) begin
        int  g;
        bit  can_load;
        if (!rst_n || clr) begin
            for (int i = 0; i < 8; i++) m_pend[i] = 1'b0;
            m_v = 1'b0; m_c = 0; m_ovf = 1'b0;
        end else begin
            can_load = !m_v || out_ready;
            g = -1;
            if (can_load)
                for (int i = 7; i >= 0; i--) if (m_pend[i]) g = i;
            m_ovf = 1'b0;
            for (int i = 0; i < 8; i++) begin
                if (req[i] && m_pend[i] && i != g) m_ovf = 1'b1;
                m_pend[i] = (m_pend[i] && i != g) || req[i];
            end
            if (can_load) begin
                if (g >= 0) begin m_v = 1'b1; m_c = g; end
                else m_v = 1'b0;
            end
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, required %0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            check("cmp_valid", {31'd0, out_valid}, {31'd0, m_v});
            check("cmp_code", {29'd0, out_code}, m_c);
            check("cmp_pending", {24'd0, pending}, {24'd0, model_vec()});
            check("cmp_cnt", {28'd0, pend_cnt}, model_cnt());
            check("cmp_ovf", {31'd0, ovf}, {31'd0, m_ovf});
        end
    end

    // Drive inputs, let one edge sample them, return at the following negedge.
    task automatic cyc(input logic [7:0] r, input logic rdy, input logic c);
        req = r; out_ready = rdy; clr = c;
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct { logic [7:0] r; logic rdy; } vec_t;
    vec_t mix [10] = '{'{8'h81, 1'b1}, '{8'h42, 1'b0}, '{8'h42, 1'b0}, '{8'h00, 1'b1},
                       '{8'h18, 1'b1}, '{8'h01, 1'b0}, '{8'hFF, 1'b1}, '{8'h00, 1'b0},
                       '{8'h80, 1'b1}, '{8'h00, 1'b1}};

    initial begin
        @(negedge clk);
        // Reset with all requests high
        rst_n = 1'b0;
        cyc(8'hFF, 1'b0, 1'b0);
        cmp_en = 1'b1;
        cyc(8'hFF, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc(8'h00, 1'b1, 1'b0);
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_pending", {24'd0, pending}, 32'd0);
        check("rst_ovf", {31'd0, ovf}, 32'd0);

        // Single event
        cyc(8'h20, 1'b1, 1'b0);
        check("single_p", {24'd0, pending}, 32'h20);
        cyc(8'h00, 1'b1, 1'b0);
        check("single_valid", {31'd0, out_valid}, 32'd1);
        check("single_code", {29'd0, out_code}, 32'd5);
        cyc(8'h00, 1'b1, 1'b0);
        check("single_idle", {31'd0, out_valid}, 32'd0);
        check("single_pend0", {24'd0, pending}, 32'd0);

        // Priority drain of 8'hA5
        cyc(8'hA5, 1'b1, 1'b0);
        check("drain_cnt4", {28'd0, pend_cnt}, 32'd4);
        cyc(8'h00, 1'b1, 1'b0);
        check("drain_c0", {29'd0, out_code}, 32'd0);
        check("drain_cnt3", {28'd0, pend_cnt}, 32'd3);
        cyc(8'h00, 1'b1, 1'b0);
        check("drain_c2", {29'd0, out_code}, 32'd2);
        check("drain_cnt2", {28'd0, pend_cnt}, 32'd2);
        cyc(8'h00, 1'b1, 1'b0);
        check("drain_c5", {29'd0, out_code}, 32'd5);
        check("drain_cnt1", {28'd0, pend_cnt}, 32'd1);
        cyc(8'h00, 1'b1, 1'b0);
        check("drain_c7", {29'd0, out_code}, 32'd7);
        check("drain_cnt0", {28'd0, pend_cnt}, 32'd0);
        cyc(8'h00, 1'b1, 1'b0);
        check("drain_end", {31'd0, out_valid}, 32'd0);

        // Backpressure and overflow
        cyc(8'h09, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        check("bp_load_code", {29'd0, out_code}, 32'd0);
        check("bp_load_valid", {31'd0, out_valid}, 32'd1);
        cyc(8'h08, 1'b0, 1'b0);
        check("bp_ovf", {31'd0, ovf}, 32'd1);
        check("bp_pending", {24'd0, pending}, 32'h08);
        check("bp_hold", {29'd0, out_code}, 32'd0);
        cyc(8'h00, 1'b0, 1'b0);
        check("bp_ovf_pulse", {31'd0, ovf}, 32'd0);
        cyc(8'h00, 1'b1, 1'b0);
        check("bp_code3", {29'd0, out_code}, 32'd3);
        cyc(8'h00, 1'b1, 1'b0);
        check("bp_end", {31'd0, out_valid}, 32'd0);

        // Same-cycle grant and re-arm
        cyc(8'h02, 1'b1, 1'b0);
        cyc(8'h02, 1'b1, 1'b0);
        check("rearm_code", {29'd0, out_code}, 32'd1);
        check("rearm_p", {24'd0, pending}, 32'h02);
        check("rearm_ovf", {31'd0, ovf}, 32'd0);
        cyc(8'h00, 1'b1, 1'b0);
        check("rearm_code2", {29'd0, out_code}, 32'd1);
        check("rearm_valid2", {31'd0, out_valid}, 32'd1);
        check("rearm_p0", {24'd0, pending}, 32'd0);
        cyc(8'h00, 1'b1, 1'b0);

        // Clear mid-stream
        cyc(8'hF1, 1'b0, 1'b0);
        cyc(8'h00, 1'b0, 1'b0);
        check("clr_pre_p", {24'd0, pending}, 32'hF0);
        check("clr_pre_v", {31'd0, out_valid}, 32'd1);
        cyc(8'h04, 1'b0, 1'b1);
        check("clr_valid", {31'd0, out_valid}, 32'd0);
        check("clr_pending", {24'd0, pending}, 32'd0);
        cyc(8'h40, 1'b1, 1'b0);
        cyc(8'h00, 1'b1, 1'b0);
        check("clr_resume", {29'd0, out_code}, 32'd6);
        check("clr_resume_v", {31'd0, out_valid}, 32'd1);

        // Mixed traffic, checked by the model only
        for (int i = 0; i < 10; i++) cyc(mix[i].r, mix[i].rdy, 1'b0);
        for (int i = 0; i < 10; i++) cyc(8'h00, 1'b1, 1'b0);
        check("mix_drained", {31'd0, out_valid}, 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
